imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
Program loader that writes the instruction memory, which the processor core only reads. It accepts a byte stream carrying a header, a payload and a checksum. It packs the payload bytes big-endian into 32-bit words, writes them through the memory's write port at consecutive addresses from 0, and then reports done or error. The core is held off until done is asserted.

Parameters:
ADDR_W, 7, instruction memory address width; matches the 7-bit PC.
DEPTH, 128, number of words in instruction memory; must equal 2**ADDR_W.
DATA_W, 32, instruction word width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERROR.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready at a clock edge.
mem_address  output  ADDR_W  write address to instruction memory.
mem_data  output  DATA_W  write data to instruction memory.
mem_wren  output  1  write enable; high for exactly one cycle per word.
busy  output  1  a load is in progress.
done  output  1  load completed and checksum matched; sticky.
error  output  1  bad header or checksum mismatch; sticky.
words_loaded  output  ADDR_W+1  number of words written in the current or last load.

Behaviour:
- Clock and reset: one clock, named clock. reset is synchronous and active-high.
- Reset values: all outputs 0 and state IDLE. Reset wins over every other input, including in the middle of a load. The first edge with reset high forces mem_wren=0.
- Registered outputs: every output is a register or is decoded from the state register. There is no combinational path from in_valid or in_data to any output.
- in_ready: 1 only in HDR_HI, HDR_LO, DATA and CHECK.
- State IDLE: start moves to HDR_HI. All byte traffic is ignored.
- State HDR_HI: an accepted byte becomes count[15:8]. Go to HDR_LO.
- State HDR_LO: an accepted byte becomes count[7:0].
  - If count==0 or count>DEPTH, go to ERROR. No memory write occurs.
  - Otherwise clear the address, word counter and checksum, then go to DATA.
- State DATA: each accepted byte shifts into the word register MSB-first (first byte goes to [31:24]) and is XORed into the running checksum. After the 4th byte of a word, go to WRITE.
- State WRITE: lasts one cycle.
  - mem_wren=1 with mem_address = current address and mem_data = the assembled word. in_ready=0.
  - At the next edge, address and words_loaded increment.
  - If words_loaded reaches count, go to CHECK; otherwise go to DATA.
  - Address never wraps: with count<=DEPTH, the last write goes to DEPTH-1.
- State CHECK: one accepted byte is compared with the XOR of all payload bytes. The header bytes are excluded from the checksum.
  - Equal: go to DONE.
  - Not equal: go to ERROR.
- States DONE and ERROR: sticky, with in_ready=0. start clears done/error and words_loaded and goes to HDR_HI.
- Flags by state:
  - busy = 1 in every state other than IDLE, DONE and ERROR.
  - done = 1 only in DONE.
  - error = 1 only in ERROR.
- start while busy: ignored, and the load in progress continues.
- Gaps in in_valid: idle cycles are allowed anywhere in the stream. The result depends only on the accepted bytes.
- Throughput: 5 cycles per word when in_valid is held high.
- Words already written when an error or reset occurs stay in memory. The loader does not undo them.

Decomposition:
- Shared package imem_loader_pkg holds:
  - the state enum (IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR);
  - default ADDR_W, DEPTH and DATA_W;
  - HDR_BYTES=2 and BYTES_PER_WORD=4.
- No sub-module. The FSM, byte packer, counters and checksum sit in one module. The packer is too thin to justify its own module.

Test Plan:
1. start, then bytes 00 02 12 34 56 78 9A BC DE F0 00 with in_valid held high -> two writes: addr0=0x12345678, addr1=0x9ABCDEF0, each with a 1-cycle mem_wren. Then done=1, error=0, words_loaded=2, busy=0.
2. Same stream with checksum byte 01 -> both writes still occur, then error=1 and done=0.
3. Header 00 00, and separately header 00 81 -> error=1 on the cycle after the second header byte, mem_wren never asserted, in_ready=0 from then on.
4. Header 00 80 followed by 128 words of pattern word i = i -> writes to addresses 0..127 in order with no wrap, correct XOR checksum, done=1, words_loaded=128.
5. Scenario 1 with in_valid toggled pseudo-randomly -> identical writes and final flags. in_ready=0 in every WRITE cycle, and no byte is lost or duplicated.
6. Reset asserted after 6 bytes of scenario 1 -> the next edge gives all outputs 0 and state IDLE. A start pulse while busy is ignored. A fresh start plus the scenario 1 stream completes with done=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned DEF_ADDR_W     = 7;
  localparam int unsigned DEF_DEPTH      = 128;
  localparam int unsigned DEF_DATA_W     = 32;
  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned CNT_W          = HDR_BYTES * BYTE_W;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR_HI = 3'd1;
  localparam logic [2:0] S_HDR_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
  localparam logic [2:0] S_CHECK  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
  localparam logic [2:0] S_ERROR  = 3'd7;

endpackage

// File: rtl/imem_loader.sv
// Streams a header/payload/checksum byte sequence into instruction memory,
// packing payload bytes big-endian into words written from address 0.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  logic [2:0]        state;
  logic [2:0]        state_next;
  logic [CNT_W-1:0]  count;
  logic [1:0]        byte_cnt;
  logic [BYTE_W-1:0] csum;

  logic              accept;
  logic [CNT_W-1:0]  hdr_count;
  logic              hdr_bad;
  logic              last_word;

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count[CNT_W-1:BYTE_W], in_data};
  assign hdr_bad   = (hdr_count == '0) || (hdr_count > CNT_W'(DEPTH));
  assign last_word = ((CNT_W'(words_loaded) + CNT_W'(1)) == count);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_HDR_HI;
      S_HDR_HI: if (accept) state_next = S_HDR_LO;
      S_HDR_LO: if (accept) state_next = hdr_bad ? S_ERROR : S_DATA;
      S_DATA:   if (accept && (byte_cnt == LAST_BYTE)) state_next = S_WRITE;
      S_WRITE:  state_next = last_word ? S_CHECK : S_DATA;
      S_CHECK:  if (accept) state_next = (in_data == csum) ? S_DONE : S_ERROR;
      default:  state_next = S_IDLE;
    endcase
  end

  // Status flags registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_ready <= 1'b0;
      mem_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      in_ready <= (state_next == S_HDR_HI) || (state_next == S_HDR_LO) ||
                  (state_next == S_DATA)   || (state_next == S_CHECK);
      mem_wren <= (state_next == S_WRITE);
      busy     <= (state_next != S_IDLE) && (state_next != S_DONE) &&
                  (state_next != S_ERROR);
      done     <= (state_next == S_DONE);
      error    <= (state_next == S_ERROR);
    end
  end

  // Header capture, word packing, checksum and address/word counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      count        <= '0;
      byte_cnt     <= '0;
      csum         <= '0;
      mem_address  <= '0;
      mem_data     <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) words_loaded <= '0;
        end
        S_HDR_HI: begin
          if (accept) count[CNT_W-1:BYTE_W] <= in_data;
        end
        S_HDR_LO: begin
          if (accept) begin
            count[BYTE_W-1:0] <= in_data;
            if (!hdr_bad) begin
              mem_address  <= '0;
              words_loaded <= '0;
              csum         <= '0;
              byte_cnt     <= '0;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            mem_data <= {mem_data[DATA_W-BYTE_W-1:0], in_data};
            csum     <= csum ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_WRITE: begin
          words_loaded <= words_loaded + (ADDR_W+1)'(1);
          // Hold the address on the final word so it never wraps past DEPTH-1.
          if (!last_word) mem_address <= mem_address + ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: nominal loads, bad header,
// bad checksum, full-depth load, stalled stream and mid-load reset.
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  words_loaded;

  int errors = 0;
  int checks = 0;

  logic [6:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  imem_loader dut (
    .clock(clock), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .busy(busy), .done(done),
    .error(error), .words_loaded(words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Log each write; one entry per cycle of mem_wren, and in_ready must be low then.
  always @(negedge clock) begin
    if (mem_wren === 1'b1) begin
      wr_addr.push_back(mem_address);
      wr_data.push_back(mem_data);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL write_in_ready: got %b want 0", in_ready);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input bit gaps);
    int idx = 0;
    int cyc = 0;
    logic xfer;
    while (idx < b.size()) begin
      @(negedge clock);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = b[idx];
      xfer     = in_valid && in_ready;
      @(posedge clock);
      if (xfer) idx++;
      cyc++;
      if (cyc > 5000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: sent %0d want %0d bytes", idx, b.size());
        break;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy === 1'b1 && cyc < 20) begin
      @(negedge clock);
      cyc++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_two_words(input string name);
    checks++;
    if (wr_addr.size() != 2) begin
      errors++;
      $display("FAIL %s_nwrites: got %0d want 2", name, wr_addr.size());
    end else begin
      checks++;
      if ({wr_addr[0], wr_data[0]} !== {7'd0, 32'h12345678}) begin
        errors++;
        $display("FAIL %s_w0: got %h/%h want 00/12345678", name, wr_addr[0], wr_data[0]);
      end
      checks++;
      if ({wr_addr[1], wr_data[1]} !== {7'd1, 32'h9ABCDEF0}) begin
        errors++;
        $display("FAIL %s_w1: got %h/%h want 01/9abcdef0", name, wr_addr[1], wr_data[1]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({in_ready, mem_wren, busy, done, error} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000", {in_ready, mem_wren, busy, done, error});
    end
    checks++;
    if ({mem_address, mem_data, words_loaded} !== 47'd0) begin
      errors++;
      $display("FAIL reset_regs: got %h/%h/%h want 0", mem_address, mem_data, words_loaded);
    end
    reset = 1'b0;
  endtask

  task automatic test_nominal(input bit gaps, input string name);
    logic [7:0] s[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                         8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    clear_log();
    pulse_start();
    send_bytes(s, gaps);
    wait_idle();
    check_two_words(name);
    checks++;
    if ({done, error, words_loaded} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL %s_final: got done=%b err=%b wl=%0d want 1 0 2", name, done, error, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                         8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
    clear_log();
    pulse_start();
    send_bytes(s, 1'b0);
    wait_idle();
    check_two_words("badsum");
    checks++;
    if ({done, error} !== 2'b01) begin
      errors++;
      $display("FAIL badsum_flags: got done=%b err=%b want 0 1", done, error);
    end
  endtask

  task automatic test_bad_header(input logic [7:0] lo, input string name);
    logic [7:0] s[$];
    s = '{8'h00, lo};
    clear_log();
    pulse_start();
    send_bytes(s, 1'b0);
    checks++;
    if ({error, done, busy, in_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL %s_flags: got err=%b done=%b busy=%b rdy=%b want 1 0 0 0",
               name, error, done, busy, in_ready);
    end
    repeat (3) @(negedge clock);
    checks++;
    if ({error, in_ready, 32'(wr_addr.size())} !== {1'b1, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL %s_sticky: got err=%b rdy=%b writes=%0d want 1 0 0",
               name, error, in_ready, wr_addr.size());
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] s[$];
    int bad = 0;
    s = '{8'h00, 8'h80};
    for (int i = 0; i < 128; i++) begin
      s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'(i));
    end
    s.push_back(8'h00);  // XOR of 0..127 is 0
    clear_log();
    pulse_start();
    send_bytes(s, 1'b0);
    wait_idle();
    checks++;
    if (wr_addr.size() != 128) begin
      errors++;
      $display("FAIL full_nwrites: got %0d want 128", wr_addr.size());
    end else begin
      for (int i = 0; i < 128; i++)
        if (wr_addr[i] !== 7'(i) || wr_data[i] !== 32'(i)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL full_contents: got %0d bad writes want 0", bad);
      end
    end
    checks++;
    if ({done, error, words_loaded, mem_address} !== {1'b1, 1'b0, 8'd128, 7'd127}) begin
      errors++;
      $display("FAIL full_final: got done=%b err=%b wl=%0d addr=%0d want 1 0 128 127",
               done, error, words_loaded, mem_address);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] p1[$] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
    logic [7:0] a[$]  = '{8'h00, 8'h02, 8'h12, 8'h34};
    logic [7:0] b[$]  = '{8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h00};
    pulse_start();
    send_bytes(p1, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++;
    if ({in_ready, mem_wren, busy, done, error, mem_address, mem_data, words_loaded} !== 52'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b wren=%b busy=%b done=%b err=%b a=%h d=%h wl=%h want 0",
               in_ready, mem_wren, busy, done, error, mem_address, mem_data, words_loaded);
    end
    reset = 1'b0;
    clear_log();
    // Start while busy must not disturb the load in progress.
    pulse_start();
    send_bytes(a, 1'b0);
    pulse_start();
    send_bytes(b, 1'b0);
    wait_idle();
    check_two_words("busystart");
    checks++;
    if ({done, error, words_loaded} !== {1'b1, 1'b0, 8'd2}) begin
      errors++;
      $display("FAIL busystart_final: got done=%b err=%b wl=%0d want 1 0 2", done, error, words_loaded);
    end
    test_nominal(1'b0, "fresh");
  endtask

  initial begin
    test_reset();
    test_nominal(1'b0, "nominal");
    test_bad_checksum();
    test_bad_header(8'h00, "hdr0");
    test_bad_header(8'h81, "hdr81");
    test_full_depth();
    test_nominal(1'b1, "gaps");
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
